// File: rtl/ibram_rd_controller.sv
// Per-bank read sequencer: streams one ping/pong input-BRAM buffer out as
// READ_WIDTH activation elements on a valid/ready stream, then releases it.
module ibram_rd_controller #(
    parameter int NUM_BANKS   = 16,
    parameter int WRITE_WIDTH = 128,
    parameter int WRITE_DEPTH = 128,
    parameter int READ_WIDTH  = 8,
    parameter int READ_DEPTH  = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH,
    localparam int R  = WRITE_WIDTH / READ_WIDTH,
    localparam int AW = $clog2(WRITE_DEPTH),
    localparam int RW = $clog2(READ_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_BANKS*(AW+1)-1:0]      write_addr_pingpong_data,
    input  logic [NUM_BANKS-1:0]             write_addr_pingpong_valid,
    output logic [NUM_BANKS-1:0]             write_addr_pingpong_ready,
    output logic [NUM_BANKS*(RW+1)-1:0]      addrB_ping_pong,
    output logic [NUM_BANKS-1:0]             enaB,
    output logic [NUM_BANKS-1:0]             weB,
    input  logic [NUM_BANKS*READ_WIDTH-1:0]  doB,
    output logic [NUM_BANKS*READ_WIDTH-1:0]  act_data,
    output logic [NUM_BANKS-1:0]             act_valid,
    output logic [NUM_BANKS-1:0]             act_last,
    input  logic [NUM_BANKS-1:0]             act_ready,
    output logic [NUM_BANKS-1:0]             buf_release,
    output logic [NUM_BANKS-1:0]             buf_release_sel
);

    localparam int                FULL_TOTAL = WRITE_DEPTH * R;
    localparam logic [RW:0]       TOTAL_MAX  = (RW+1)'(FULL_TOTAL);
    localparam logic [RW:0]       R_ELEMS    = (RW+1)'(R);
    localparam logic [RW:0]       ONE        = (RW+1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    // Keeps ready low while in reset and for the partial cycle after deassertion.
    logic rdy_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    assign weB = '0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        state_t                 state, state_nxt;
        logic                   sel_q;
        logic [RW:0]            total_q;
        logic [RW:0]            idx_q;
        logic                   infl_q;
        logic                   infl_last_q;
        logic [READ_WIDTH-1:0]  fifo_data [4];
        logic [3:0]             fifo_last;
        logic [1:0]             wr_ptr;
        logic [1:0]             rd_ptr;
        logic [2:0]             cnt;
        logic                   desc_sel;
        logic [AW-1:0]          desc_cnt;
        logic [RW:0]            desc_total;
        logic [2:0]             pending;
        logic                   is_last;
        logic                   drained;
        logic                   ready;
        logic                   accept;
        logic                   issue;
        logic                   release_now;
        logic                   push;
        logic                   pop;

        assign desc_sel   = write_addr_pingpong_data[b*(AW+1)];
        assign desc_cnt   = write_addr_pingpong_data[b*(AW+1)+1 +: AW];
        assign desc_total = (desc_cnt == '0) ? TOTAL_MAX : (RW+1)'(desc_cnt) * R_ELEMS;

        // Pending counts buffered elements plus the read whose data arrives next cycle.
        assign pending = cnt + 3'(infl_q);
        assign is_last = (idx_q == total_q - ONE);
        assign drained = (cnt == 3'd0) && !infl_q;
        assign push    = infl_q;
        assign pop     = (cnt != 3'd0) && act_ready[b];
        assign accept  = ready && write_addr_pingpong_valid[b];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state <= IDLE;
            else        state <= state_nxt;
        end

        // A drained buffer is released and a new descriptor may be taken in the same cycle.
        always_comb begin
            state_nxt   = state;
            ready       = 1'b0;
            issue       = 1'b0;
            release_now = 1'b0;
            case (state)
                IDLE: begin
                    ready = rdy_en;
                    if (accept) state_nxt = READ;
                end
                READ: begin
                    issue = (pending < 3'd4);
                    if (issue && is_last) state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        release_now = 1'b1;
                        ready       = rdy_en;
                        state_nxt   = accept ? READ : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sel_q       <= 1'b0;
                total_q     <= '0;
                idx_q       <= '0;
                infl_q      <= 1'b0;
                infl_last_q <= 1'b0;
            end else begin
                if (accept) begin
                    sel_q   <= desc_sel;
                    total_q <= desc_total;
                    idx_q   <= '0;
                end else if (issue && !is_last) begin
                    idx_q <= idx_q + ONE;
                end
                infl_q      <= issue;
                infl_last_q <= issue && is_last;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                cnt       <= '0;
                fifo_last <= '0;
            end else begin
                if (push) begin
                    fifo_last[wr_ptr] <= infl_last_q;
                    wr_ptr            <= wr_ptr + 2'd1;
                end
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 3'd1;
                    2'b01:   cnt <= cnt - 3'd1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage needs no reset: every output read from it is gated by the occupancy count.
        always_ff @(posedge clk) begin
            if (push) fifo_data[wr_ptr] <= doB[b*READ_WIDTH +: READ_WIDTH];
        end

        assign write_addr_pingpong_ready[b]         = ready;
        assign enaB[b]                              = issue;
        assign addrB_ping_pong[b*(RW+1) +: (RW+1)]  = issue ? {sel_q, idx_q[RW-1:0]} : '0;
        assign act_valid[b]                         = (cnt != 3'd0);
        assign act_last[b]                          = (cnt != 3'd0) && fifo_last[rd_ptr];
        assign act_data[b*READ_WIDTH +: READ_WIDTH] = (cnt != 3'd0) ? fifo_data[rd_ptr] : '0;
        assign buf_release[b]                       = release_now;
        assign buf_release_sel[b]                   = release_now && sel_q;
    end

endmodule

// File: tb/tb_ibram_rd_controller.sv
// Directed bench for ibram_rd_controller: BRAM model, per-bank drivers and
// stream monitors, a descriptor table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_ibram_rd_controller;

    localparam int NB  = 16;
    localparam int AW  = 7;
    localparam int RW  = 11;
    localparam int ADW = RW + 1;
    localparam int DW  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NB*(AW+1)-1:0] write_addr_pingpong_data;
    logic [NB-1:0]        write_addr_pingpong_valid;
    logic [NB-1:0]        write_addr_pingpong_ready;
    logic [NB*ADW-1:0]    addrB_ping_pong;
    logic [NB-1:0]        enaB;
    logic [NB-1:0]        weB;
    logic [NB*DW-1:0]     doB;
    logic [NB*DW-1:0]     act_data;
    logic [NB-1:0]        act_valid;
    logic [NB-1:0]        act_last;
    logic [NB-1:0]        act_ready;
    logic [NB-1:0]        buf_release;
    logic [NB-1:0]        buf_release_sel;

    typedef struct {logic sel; int count;} req_t;
    typedef struct {logic sel; int total;} exp_t;
    typedef struct {int bank; int count; logic sel; int rmode; int exp_elems;} vec_t;

    req_t req_q [NB][$];
    exp_t exp_q [NB][$];
    int   rmode [NB];
    int   rx_idx [NB];
    int   iss_idx [NB];
    int   rel_cnt [NB];
    int   last_rel_elems [NB];
    logic last_rel_sel [NB];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ibram_rd_controller dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .write_addr_pingpong_data  (write_addr_pingpong_data),
        .write_addr_pingpong_valid (write_addr_pingpong_valid),
        .write_addr_pingpong_ready (write_addr_pingpong_ready),
        .addrB_ping_pong           (addrB_ping_pong),
        .enaB                      (enaB),
        .weB                       (weB),
        .doB                       (doB),
        .act_data                  (act_data),
        .act_valid                 (act_valid),
        .act_last                  (act_last),
        .act_ready                 (act_ready),
        .buf_release               (buf_release),
        .buf_release_sel           (buf_release_sel)
    );

    function automatic logic [7:0] mem_val(input int b, input logic s, input int idx);
        return 8'(idx * 3 + (idx >> 8) + b * 17 + (s ? 85 : 0));
    endfunction

    task automatic checkOutput(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input int b, input int count, input logic sel);
        req_t r;
        r.sel   = sel;
        r.count = count;
        req_q[b].push_back(r);
    endtask

    task automatic wait_rel(input int b, input int target, input int budget);
        int n;
        n = 0;
        while (rel_cnt[b] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("release_seen_b%0d", b), longint'(rel_cnt[b] >= target), 1);
    endtask

    for (genvar g = 0; g < NB; g++) begin : g_tb
        logic           dv;
        logic [AW:0]    dd;
        logic           ar;
        logic [DW-1:0]  dob_r;

        assign write_addr_pingpong_data[g*(AW+1) +: (AW+1)] = dd;
        assign write_addr_pingpong_valid[g]                 = dv;
        assign act_ready[g]                                 = ar;
        assign doB[g*DW +: DW]                              = dob_r;

        // BRAM port B model: registered read, garbage when not enabled.
        always @(posedge clk)
            dob_r <= enaB[g] ? mem_val(g, addrB_ping_pong[g*ADW+RW], int'(addrB_ping_pong[g*ADW +: RW]))
                             : 8'($urandom);

        // Descriptor driver and consumer-ready generator.
        initial begin : drv
            logic hs;
            dv = 1'b0;
            dd = '0;
            ar = 1'b0;
            forever begin
                @(negedge clk);
                hs = dv && write_addr_pingpong_ready[g];
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    dv = 1'b0;
                    req_q[g].delete();
                    continue;
                end
                case (rmode[g])
                    0:       ar = 1'b1;
                    1:       ar = !ar;
                    2:       ar = 1'($urandom_range(0, 1));
                    default: ar = 1'b0;
                endcase
                if (hs) begin
                    void'(req_q[g].pop_front());
                    dv = 1'b0;
                end
                if (!dv && req_q[g].size() != 0) begin
                    dd = {req_q[g][0].count[AW-1:0], req_q[g][0].sel};
                    dv = 1'b1;
                end
            end
        end

        // Stream monitor: addresses, pending limit, data order, last, stability, release.
        initial begin : mon
            logic          stall_prev;
            logic [DW-1:0] pdata;
            logic          plast;
            logic          last_hs;
            logic          arm;
            int            lat;
            exp_t          e;
            exp_t          ne;
            stall_prev = 1'b0;
            pdata      = '0;
            plast      = 1'b0;
            last_hs    = 1'b0;
            arm        = 1'b0;
            lat        = 0;
            rel_cnt[g] = 0;
            rx_idx[g]  = 0;
            iss_idx[g] = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q[g].delete();
                    rx_idx[g]  = 0;
                    iss_idx[g] = 0;
                    stall_prev = 1'b0;
                    last_hs    = 1'b0;
                    arm        = 1'b0;
                    continue;
                end
                if (arm) begin
                    lat++;
                    if (act_valid[g]) begin
                        checkOutput($sformatf("first_valid_latency_b%0d", g), lat, 3);
                        arm = 1'b0;
                    end
                end
                if (last_hs) begin
                    checkOutput($sformatf("release_after_last_b%0d", g), buf_release[g], 1);
                    last_hs = 1'b0;
                end
                if (buf_release[g]) begin
                    checkOutput($sformatf("ready_at_release_b%0d", g), write_addr_pingpong_ready[g], 1);
                    checkOutput($sformatf("weB_b%0d", g), weB[g], 0);
                    if (exp_q[g].size() == 0) begin
                        checkOutput($sformatf("unexpected_release_b%0d", g), 1, 0);
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput($sformatf("release_sel_b%0d", g), buf_release_sel[g], longint'(e.sel));
                        checkOutput($sformatf("release_count_b%0d", g), rx_idx[g], e.total);
                        last_rel_sel[g] = e.sel;
                    end
                    last_rel_elems[g] = rx_idx[g];
                    rel_cnt[g]++;
                    rx_idx[g]  = 0;
                    iss_idx[g] = 0;
                end
                if (stall_prev) begin
                    checkOutput($sformatf("stall_valid_b%0d", g), act_valid[g], 1);
                    checkOutput($sformatf("stall_data_b%0d", g), act_data[g*DW +: DW], pdata);
                    checkOutput($sformatf("stall_last_b%0d", g), act_last[g], longint'(plast));
                end
                if (enaB[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput($sformatf("unexpected_enaB_b%0d", g), 1, 0);
                    end else begin
                        e = exp_q[g][0];
                        checkOutput($sformatf("addrB_b%0d_i%0d", g, iss_idx[g]),
                                    addrB_ping_pong[g*ADW +: ADW], longint'({e.sel, 11'(iss_idx[g])}));
                        checkOutput($sformatf("issue_bound_b%0d", g), longint'(iss_idx[g] < e.total), 1);
                        checkOutput($sformatf("pending_limit_b%0d", g), longint'((iss_idx[g] - rx_idx[g]) < 4), 1);
                    end
                    iss_idx[g]++;
                end else begin
                    checkOutput($sformatf("addrB_idle_b%0d", g), addrB_ping_pong[g*ADW +: ADW], 0);
                end
                if (act_valid[g] && act_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput($sformatf("unexpected_elem_b%0d", g), 1, 0);
                    end else begin
                        e = exp_q[g][0];
                        checkOutput($sformatf("elem_data_b%0d_i%0d", g, rx_idx[g]),
                                    act_data[g*DW +: DW], mem_val(g, e.sel, rx_idx[g]));
                        checkOutput($sformatf("elem_last_b%0d_i%0d", g, rx_idx[g]),
                                    act_last[g], longint'(rx_idx[g] == e.total - 1));
                        if (rx_idx[g] == e.total - 1) last_hs = 1'b1;
                    end
                    rx_idx[g]++;
                end
                stall_prev = act_valid[g] && !act_ready[g];
                pdata      = act_data[g*DW +: DW];
                plast      = act_last[g];
                if (dv && write_addr_pingpong_ready[g]) begin
                    ne.sel   = dd[0];
                    ne.total = (dd[AW:1] == '0) ? 2048 : int'(dd[AW:1]) * 16;
                    exp_q[g].push_back(ne);
                    arm = 1'b1;
                    lat = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t vecs [6];
        int   base [NB];
        int   b;

        vecs[0] = '{bank:0,  count:1,   sel:1'b0, rmode:0, exp_elems:16};
        vecs[1] = '{bank:0,  count:0,   sel:1'b1, rmode:0, exp_elems:2048};
        vecs[2] = '{bank:2,  count:2,   sel:1'b0, rmode:1, exp_elems:32};
        vecs[3] = '{bank:5,  count:3,   sel:1'b1, rmode:2, exp_elems:48};
        vecs[4] = '{bank:15, count:127, sel:1'b1, rmode:0, exp_elems:2032};
        vecs[5] = '{bank:7,  count:5,   sel:1'b0, rmode:2, exp_elems:80};

        for (int i = 0; i < NB; i++) rmode[i] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_enaB", enaB, 0);
        checkOutput("reset_addrB", longint'(|addrB_ping_pong), 0);
        checkOutput("reset_act_valid", act_valid, 0);
        checkOutput("reset_act_last", act_last, 0);
        checkOutput("reset_act_data", longint'(|act_data), 0);
        checkOutput("reset_buf_release", buf_release, 0);
        checkOutput("reset_buf_release_sel", buf_release_sel, 0);
        checkOutput("reset_ready", write_addr_pingpong_ready, 0);
        #1 rst_n = 1'b1;
        #1 checkOutput("ready_before_first_clk", write_addr_pingpong_ready, 0);
        @(posedge clk);
        #1 checkOutput("ready_after_first_clk", write_addr_pingpong_ready, 16'hFFFF);

        for (int i = 0; i < 6; i++) begin
            b        = vecs[i].bank;
            base[b]  = rel_cnt[b];
            rmode[b] = vecs[i].rmode;
            applyStimulus(b, vecs[i].count, vecs[i].sel);
            wait_rel(b, base[b] + 1, 10000);
            checkOutput($sformatf("vec%0d_elems", i), last_rel_elems[b], vecs[i].exp_elems);
            checkOutput($sformatf("vec%0d_sel", i), longint'(last_rel_sel[b]), longint'(vecs[i].sel));
        end

        // Toggle ready, then hold it low: issue must stall with four elements outstanding.
        base[4]  = rel_cnt[4];
        rmode[4] = 1;
        applyStimulus(4, 2, 1'b0);
        repeat (12) @(negedge clk);
        rmode[4] = 3;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("bp_enaB_stalled", enaB[4], 0);
        checkOutput("bp_pending", iss_idx[4] - rx_idx[4], 4);
        checkOutput("bp_valid_held", act_valid[4], 1);
        rmode[4] = 0;
        wait_rel(4, base[4] + 1, 1000);
        checkOutput("bp_elems", last_rel_elems[4], 32);

        // Back-to-back descriptors held valid on bank 1.
        base[1] = rel_cnt[1];
        applyStimulus(1, 1, 1'b0);
        applyStimulus(1, 2, 1'b1);
        wait_rel(1, base[1] + 1, 1000);
        checkOutput("b2b_first_elems", last_rel_elems[1], 16);
        wait_rel(1, base[1] + 2, 1000);
        checkOutput("b2b_second_elems", last_rel_elems[1], 32);
        checkOutput("b2b_second_sel", longint'(last_rel_sel[1]), 1);

        // All banks at once with random backpressure.
        for (int i = 0; i < NB; i++) begin
            base[i]  = rel_cnt[i];
            rmode[i] = 2;
            applyStimulus(i, (i % 4) + 1, 1'(i & 1));
        end
        for (int i = 0; i < NB; i++) begin
            wait_rel(i, base[i] + 1, 2000);
            checkOutput($sformatf("multi_elems_b%0d", i), last_rel_elems[i], ((i % 4) + 1) * 16);
            checkOutput($sformatf("multi_sel_b%0d", i), longint'(last_rel_sel[i]), i & 1);
        end

        // Reset in the middle of a bank 3 stream.
        for (int i = 0; i < NB; i++) rmode[i] = 0;
        applyStimulus(3, 4, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_enaB", enaB, 0);
        checkOutput("midrst_addrB", longint'(|addrB_ping_pong), 0);
        checkOutput("midrst_act_valid", act_valid, 0);
        checkOutput("midrst_act_data", longint'(|act_data), 0);
        checkOutput("midrst_ready", write_addr_pingpong_ready, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_no_release", buf_release, 0);
        end
        #2 rst_n = 1'b1;
        #1 checkOutput("midrst_ready_before_clk", write_addr_pingpong_ready, 0);
        @(posedge clk);
        #1 checkOutput("midrst_ready_after_clk", write_addr_pingpong_ready, 16'hFFFF);
        @(negedge clk);
        base[3] = rel_cnt[3];
        applyStimulus(3, 1, 1'b1);
        wait_rel(3, base[3] + 1, 1000);
        checkOutput("postrst_elems", last_rel_elems[3], 16);
        checkOutput("postrst_sel", longint'(last_rel_sel[3]), 1);
        repeat (5) @(negedge clk);
        checkOutput("postrst_single_release", rel_cnt[3], base[3] + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
